// File: rtl/zone_bl_frame_tx.sv
// Purpose : double-buffer one frame of per-zone backlight levels and shift it MSB-first to the MiniLED driver chain.
// Latency : transmission starts the cycle after an accepted sync edge; ZONES*(1+2*DW*CLK_DIV)+LAT_CYC+1 cycles to tx_busy low.
// Backpress: none on the write side; a sync edge while busy is dropped and flagged on frame_drop.
module zone_bl_frame_tx #(
   parameter int ZONES   = 360,
   parameter int DW      = 8,
   parameter int CLK_DIV = 4,
   parameter int LAT_CYC = 8
) (
   input  logic          i_pix_clk,
   input  logic          rst,
   input  logic          zone_valid,
   input  logic [8:0]    zone_idx,
   input  logic [DW-1:0] zone_data,
   input  logic          r_Vsync_0,
   output logic          led_sclk,
   output logic          led_sdi,
   output logic          led_lat,
   output logic          tx_busy,
   output logic          frame_drop,
   output logic          idx_err
);

   localparam int AW   = (ZONES > 1) ? $clog2(ZONES) : 1;
   localparam int BW   = (DW > 1) ? $clog2(DW) : 1;
   localparam int CMAX = (2*CLK_DIV > LAT_CYC) ? 2*CLK_DIV : LAT_CYC;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [8:0]    ZONES_W  = 9'(ZONES);
   localparam logic [8:0]    Z_LAST   = 9'(ZONES - 1);
   localparam logic [CW-1:0] HALF     = CW'(CLK_DIV);
   localparam logic [CW-1:0] BIT_LAST = CW'(2*CLK_DIV - 1);
   localparam logic [CW-1:0] LAT_LAST = CW'(LAT_CYC - 1);
   localparam logic [BW-1:0] B_TOP    = BW'(DW - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

   state_t state, state_nxt;

   logic [DW-1:0] mem [2][ZONES];
   logic          wbank;
   logic          rbank;
   logic          wr_seen;
   logic          vs_d;
   logic [8:0]    z;
   logic [BW-1:0] b;
   logic [CW-1:0] cnt;
   logic [DW-1:0] sr;

   logic vs_edge;
   logic wr_ok;
   logic accept;
   logic bit_end;
   logic lat_end;

   assign vs_edge = r_Vsync_0 & ~vs_d;
   assign wr_ok   = zone_valid & (zone_idx < ZONES_W);
   // Only IDLE accepts a frame, so the read bank is never the bank being written.
   assign accept  = vs_edge & (state == IDLE) & wr_seen;
   assign bit_end = (state == SHIFT) & (cnt == BIT_LAST);
   assign lat_end = (state == LATCH) & (cnt == LAT_LAST);

   // Zone level storage; contents survive reset.
   always_ff @(posedge i_pix_clk) begin
      if (wr_ok) mem[wbank][zone_idx[AW-1:0]] <= zone_data;
   end

   // Sync edge detect, bank swap, write tracking and status flags.
   always_ff @(posedge i_pix_clk) begin
      if (rst) begin
         vs_d       <= 1'b0;
         wbank      <= 1'b0;
         wr_seen    <= 1'b0;
         frame_drop <= 1'b0;
         idx_err    <= 1'b0;
      end else begin
         vs_d       <= r_Vsync_0;
         frame_drop <= vs_edge & tx_busy;
         if (zone_valid && !wr_ok) idx_err <= 1'b1;
         // A write coincident with the swap lands in the outgoing bank, so it
         // belongs to the frame being sent and must not mark the new bank dirty.
         if (accept) begin
            wbank   <= ~wbank;
            wr_seen <= 1'b0;
         end else if (wr_ok) begin
            wr_seen <= 1'b1;
         end
      end
   end

   // Transmit FSM state register.
   always_ff @(posedge i_pix_clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and Moore outputs.
   always_comb begin
      state_nxt = state;
      led_sclk  = 1'b0;
      led_sdi   = 1'b0;
      led_lat   = 1'b0;
      tx_busy   = 1'b1;
      case (state)
         IDLE: begin
            tx_busy = 1'b0;
            if (accept) state_nxt = LOAD;
         end
         LOAD: begin
            state_nxt = SHIFT;
         end
         SHIFT: begin
            led_sclk = (cnt >= HALF);
            led_sdi  = sr[DW-1];
            if (bit_end && (b == '0)) state_nxt = (z == Z_LAST) ? LATCH : LOAD;
         end
         LATCH: begin
            led_lat = 1'b1;
            if (lat_end) state_nxt = IDLE;
         end
         default: begin
            tx_busy   = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Zone/bit/phase counters and the output shift register.
   always_ff @(posedge i_pix_clk) begin
      if (rst) begin
         z     <= '0;
         b     <= '0;
         cnt   <= '0;
         sr    <= '0;
         rbank <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (accept) begin
                  z     <= '0;
                  rbank <= wbank;
               end
            end
            LOAD: begin
               sr  <= mem[rbank][z[AW-1:0]];
               b   <= B_TOP;
               cnt <= '0;
            end
            SHIFT: begin
               if (bit_end) begin
                  cnt <= '0;
                  sr  <= sr << 1;
                  if (b == '0) begin
                     if (z != Z_LAST) z <= z + 9'd1;
                  end else begin
                     b <= b - BW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            LATCH: begin
               cnt <= lat_end ? '0 : cnt + CW'(1);
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_zone_bl_frame_tx.sv
// Purpose : directed + randomized check of zone_bl_frame_tx against a bank-level frame model.
// Latency : n/a (testbench).
// Backpress: n/a (testbench).
module tb_zone_bl_frame_tx;

   localparam int ZONES   = 4;
   localparam int DW      = 8;
   localparam int CLK_DIV = 1;
   localparam int LAT_CYC = 2;
   localparam int FLEN    = ZONES*(1 + DW*2*CLK_DIV) + LAT_CYC + 1;

   logic       i_pix_clk;
   logic       rst;
   logic       zone_valid;
   logic [8:0] zone_idx;
   logic [7:0] zone_data;
   logic       r_Vsync_0;
   logic       led_sclk;
   logic       led_sdi;
   logic       led_lat;
   logic       tx_busy;
   logic       frame_drop;
   logic       idx_err;

   int total = 0;
   int bad   = 0;

   zone_bl_frame_tx #(
      .ZONES(ZONES), .DW(DW), .CLK_DIV(CLK_DIV), .LAT_CYC(LAT_CYC)
   ) dut (
      .i_pix_clk (i_pix_clk),
      .rst       (rst),
      .zone_valid(zone_valid),
      .zone_idx  (zone_idx),
      .zone_data (zone_data),
      .r_Vsync_0 (r_Vsync_0),
      .led_sclk  (led_sclk),
      .led_sdi   (led_sdi),
      .led_lat   (led_lat),
      .tx_busy   (tx_busy),
      .frame_drop(frame_drop),
      .idx_err   (idx_err)
   );

   initial i_pix_clk = 1'b0;
   always #5 i_pix_clk = ~i_pix_clk;

   // Wire monitor: captures sdi on each sclk rising edge and counts pin activity.
   bit   bits[$];
   int   rise_cnt = 0;
   int   lat_cnt  = 0;
   int   drop_cnt = 0;
   int   viol     = 0;
   logic p_sclk   = 1'b0;
   logic p_sdi    = 1'b0;

   always @(negedge i_pix_clk) begin
      if (led_sclk && !p_sclk) begin
         bits.push_back(led_sdi);
         rise_cnt++;
      end
      if (led_sclk && p_sclk && (led_sdi !== p_sdi)) viol++;
      if (led_lat) lat_cnt++;
      if (frame_drop) drop_cnt++;
      p_sclk = led_sclk;
      p_sdi  = led_sdi;
   end

   // Reference model: two banks of zone levels, the bank being written, dirty flag, sticky error.
   logic [7:0] mbank [2][ZONES];
   bit         m_wbank = 1'b0;
   bit         m_seen  = 1'b0;
   bit         m_err   = 1'b0;

   function automatic void mwrite(input int idx, input logic [7:0] d);
      if (idx < ZONES) begin
         mbank[m_wbank][idx] = d;
         m_seen = 1'b1;
      end else begin
         m_err = 1'b1;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_pix_clk);
      #1;
   endtask

   task automatic wr(input int idx, input logic [7:0] d);
      zone_valid = 1'b1;
      zone_idx   = 9'(idx);
      zone_data  = d;
      mwrite(idx, d);
      tick();
      zone_valid = 1'b0;
   endtask

   // One sync edge plus a bounded observation window; optional write coincident
   // with the edge, optional second edge while busy with writes to the new bank.
   task automatic frame(input string tag, input bit cw_en, input int cw_idx,
                        input logic [7:0] cw_dat, input bit drop_test);
      int         r0, b0, l0, d0, fin, busy_n;
      bit         exp_tx;
      logic [7:0] exp_b [ZONES];
      logic [7:0] got;
      logic [7:0] d;
      r0 = rise_cnt; b0 = bits.size(); l0 = lat_cnt; d0 = drop_cnt;
      fin = -1; busy_n = 0;
      exp_tx = m_seen;
      if (cw_en) mwrite(cw_idx, cw_dat);
      if (exp_tx) begin
         for (int zz = 0; zz < ZONES; zz++) exp_b[zz] = mbank[m_wbank][zz];
         m_wbank = ~m_wbank;
         m_seen  = 1'b0;
      end
      r_Vsync_0  = 1'b1;
      zone_valid = cw_en;
      zone_idx   = 9'(cw_idx);
      zone_data  = cw_dat;
      tick();
      zone_valid = 1'b0;
      chk($sformatf("%s/busy_next", tag), tx_busy, exp_tx);
      for (int n = 1; n <= FLEN + 20; n++) begin
         if (tx_busy) busy_n++;
         else if (fin < 0) fin = n;
         if (n == 3) r_Vsync_0 = 1'b0;
         if (drop_test && n == 10) r_Vsync_0 = 1'b1;
         if (drop_test && n == 12) r_Vsync_0 = 1'b0;
         zone_valid = 1'b0;
         if (drop_test && n >= 20 && n < 20 + ZONES) begin
            d = 8'($urandom);
            zone_valid = 1'b1;
            zone_idx   = 9'(n - 20);
            zone_data  = d;
            mwrite(n - 20, d);
         end
         tick();
      end
      zone_valid = 1'b0;
      if (exp_tx) chk($sformatf("%s/len", tag), fin, FLEN);
      else        chk($sformatf("%s/busy_cyc", tag), busy_n, 0);
      chk($sformatf("%s/sclk_rises", tag), rise_cnt - r0, exp_tx ? ZONES*DW : 0);
      chk($sformatf("%s/lat_cyc", tag), lat_cnt - l0, exp_tx ? LAT_CYC : 0);
      chk($sformatf("%s/drop", tag), drop_cnt - d0, drop_test ? 1 : 0);
      chk($sformatf("%s/sdi_stable", tag), viol, 0);
      chk($sformatf("%s/idx_err", tag), idx_err, m_err);
      if (exp_tx) begin
         if (bits.size() >= b0 + ZONES*DW) begin
            for (int zz = 0; zz < ZONES; zz++) begin
               got = '0;
               for (int k = 0; k < DW; k++) got = {got[6:0], 1'(bits[b0 + zz*DW + k])};
               chk($sformatf("%s/zone%0d", tag, zz), got, exp_b[zz]);
            end
         end else begin
            chk($sformatf("%s/bit_count", tag), bits.size() - b0, ZONES*DW);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int         b0, r1, n;
      logic [7:0] rd;
      rst = 1'b1; zone_valid = 1'b0; zone_idx = '0; zone_data = '0; r_Vsync_0 = 1'b0;
      repeat (3) tick();
      chk("rst/sclk", led_sclk, 0);
      chk("rst/sdi", led_sdi, 0);
      chk("rst/lat", led_lat, 0);
      chk("rst/busy", tx_busy, 0);
      chk("rst/drop", frame_drop, 0);
      chk("rst/idx_err", idx_err, 0);
      rst = 1'b0;
      tick();

      // Known frame, with a second sync while busy and refill of the other bank.
      wr(0, 8'hA5); wr(1, 8'h3C); wr(2, 8'hFF); wr(3, 8'h00);
      frame("known", 1'b0, 0, 8'h00, 1'b1);
      frame("bank1", 1'b0, 0, 8'h00, 1'b0);

      // Sync with nothing written since the last swap.
      frame("nowr", 1'b0, 0, 8'h00, 1'b0);

      // Out-of-range index: sticky error, no write, no dirty flag.
      wr(4, 8'h77);
      chk("idx/err_set", idx_err, 1);
      wr($urandom_range(5, 511), 8'($urandom));
      repeat (5) tick();
      chk("idx/err_sticky", idx_err, 1);
      frame("inv_only", 1'b0, 0, 8'h00, 1'b0);
      rd = 8'($urandom);
      wr(1, rd);
      frame("after_inv", 1'b0, 0, 8'h00, 1'b0);

      // Reset in the middle of shifting zone 2.
      wr(2, 8'($urandom));
      b0 = bits.size();
      r_Vsync_0 = 1'b1;
      m_wbank = ~m_wbank;
      m_seen  = 1'b0;
      tick();
      n = 0;
      while (bits.size() < b0 + 2*DW + 3 && n < 300) begin
         if (n == 2) r_Vsync_0 = 1'b0;
         tick();
         n++;
      end
      r_Vsync_0 = 1'b0;
      chk("mid/reached_zone2", bits.size() >= b0 + 2*DW + 3, 1);
      rst = 1'b1;
      tick();
      chk("mid/sclk", led_sclk, 0);
      chk("mid/sdi", led_sdi, 0);
      chk("mid/lat", led_lat, 0);
      chk("mid/busy", tx_busy, 0);
      chk("mid/idx_err", idx_err, 0);
      rst = 1'b0;
      m_wbank = 1'b0; m_seen = 1'b0; m_err = 1'b0;
      r1 = rise_cnt;
      repeat (10) tick();
      chk("mid/quiet_sclk", rise_cnt - r1, 0);
      wr(0, 8'($urandom));
      frame("after_rst", 1'b0, 0, 8'h00, 1'b0);

      // Write coincident with the sync edge joins the outgoing frame.
      wr(0, 8'($urandom));
      frame("coincident", 1'b1, 3, 8'h5A, 1'b0);

      // Randomized write bursts (some out of range, some repeated) then a sync.
      for (int it = 0; it < 4; it++) begin
         int k;
         k = $urandom_range(1, 6);
         for (int j = 0; j < k; j++) wr($urandom_range(0, 5), 8'($urandom));
         frame($sformatf("rand%0d", it), 1'b0, 0, 8'h00, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
